dcache_wb: RTL and testbench
============================

// Module: dcache_wb
// PURPOSE
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the memory
// arbiter. Serves aligned 64-bit loads/stores from 64-byte lines, fills/evicts whole lines over
// the arbiter's data port, and supports a per-line flush (clflush) for the core.
// PARAMETERS
// SETS       64   number of lines (power of two); index = addr[6+$clog2(SETS)-1:6]
// LINE_BYTES 64   line size; fixed, matches the 512-bit arbiter data path
// PORTS
// clk        in   1    core clock (bus clock)
// reset_n    in   1    asynchronous, active-low reset
// enable     in   1    request from MEM stage; held high until done
// wenable    in   1    1=store, 0=load; stable while enable
// clflush    in   1    flush request for line of addr; stable while enable; overrides wenable
// addr       in   64   byte address; addr[2:0] ignored (8-byte aligned word)
// rdata      out  64   load data, valid in the done cycle
// wdata      in   64   store data; stable while enable
// done       out  1    one-cycle completion pulse
// drequest   out  1    line transfer request to arbiter
// dreqack    in   1    arbiter accepted drequest
// dwrenable  out  1    1=line write-back, 0=line fill; stable with drequest
// daddr      out  64   line address (addr[5:0]=0)
// drdata     in   512  fill line, valid when ddone (byte 0 in bits [7:0])
// dwdata     out  512  write-back line, stable from drequest until ddone
// ddone      in   1    arbiter transfer complete pulse
// BEHAVIOUR
// - Reset (async, reset_n=0): all valid and dirty bits cleared, FSM->IDLE, done=0, drequest=0,
//   dwrenable=0, daddr=0, rdata=0. Reset mid-transfer abandons the transfer; no done issued.
// - Per line: valid, dirty, tag=addr[63:6+log2(SETS)], 512-bit data. Word w=addr[5:3].
// - FSM: IDLE -> LOOKUP on enable. LOOKUP:
//   * load hit: rdata=word w, done pulse, -> IDLE. Hit latency: done 1 cycle after enable sampled.
//   * store hit: write word w, set dirty, done pulse, -> IDLE. No arbiter traffic.
//   * miss, victim valid&dirty -> WB_REQ; miss otherwise -> FILL_REQ.
//   * clflush: if line hits and dirty -> FL_WB_REQ; else clear valid, done, -> IDLE.
//     Flush of a miss is a no-op completing in 1 cycle.
// - WB_REQ: drequest=1, dwrenable=1, daddr={victim tag,index,6'b0}, dwdata=victim line;
//   on dreqack drop drequest -> WB_WAIT; on ddone -> FILL_REQ (FL_WB path: clear valid+dirty,
//   done, -> IDLE).
// - FILL_REQ: drequest=1, dwrenable=0, daddr={addr[63:6],6'b0}; on dreqack -> FILL_WAIT;
//   on ddone write drdata into line, valid=1, tag updated, dirty=0, -> LOOKUP (replays
//   access as a hit: a store merges wdata and sets dirty).
// - drequest held high until dreqack; one request outstanding at a time. dreqack and ddone
//   in the same cycle are accepted (treated as ack then done).
// - If enable drops during a miss, the in-flight line transfer completes, the line is installed
//   and FSM returns to IDLE without done. New enable is only sampled in IDLE.
// - done never asserted together with drequest; done is a single-cycle pulse per request;
//   enable still high in the cycle after done begins a new request.
// - rdata holds the last load value until the next load completes.
// TESTING
// 1) Cold load 0x1000, fill drdata word0=0x1122334455667788 -> drequest daddr=0x1000 dwrenable=0;
//    after ddone, done with rdata=0x1122334455667788.
// 2) Load 0x1008 after (1) -> done 1 cycle after enable, rdata=fill word1, drequest stays 0.
// 3) Store 0x1010 wdata=0xDEADBEEF, then load 0x1010 -> both hit, rdata=0xDEADBEEF, no bus traffic.
// 4) Load 0x1000+SETS*64 (conflict) -> write-back daddr=0x1000, dwdata word2=0xDEADBEEF,
//    then fill daddr=0x2000, done.
// 5) clflush dirty line -> one write-back then done; following load to it misses and refills;
//    clflush of absent line -> done next cycle, no drequest.
// 6) reset_n low during FILL_WAIT -> drequest=0, done=0 immediately; reload of 0x1000 misses.

Source files
------------

// File: rtl/dcache_wb_if.sv
// Bundle of the core-side request port and the arbiter line-transfer port of dcache_wb.
// The slave modport is the cache; the master modport is the core/arbiter side.
interface dcache_wb_if;
  logic         enable;
  logic         wenable;
  logic         clflush;
  logic [63:0]  addr;
  logic [63:0]  rdata;
  logic [63:0]  wdata;
  logic         done;
  logic         drequest;
  logic         dreqack;
  logic         dwrenable;
  logic [63:0]  daddr;
  logic [511:0] drdata;
  logic [511:0] dwdata;
  logic         ddone;

  modport slave (
    input  enable, wenable, clflush, addr, wdata, dreqack, drdata, ddone,
    output rdata, done, drequest, dwrenable, daddr, dwdata
  );

  modport master (
    output enable, wenable, clflush, addr, wdata, dreqack, drdata, ddone,
    input  rdata, done, drequest, dwrenable, daddr, dwdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate L1 data cache with 64-byte lines and per-line flush.
// Misses write back a dirty victim, fill the line, then replay the access as a hit.
module dcache_wb #(
  parameter int SETS = 64
) (
  input logic        clk,
  input logic        reset_n,
  dcache_wb_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 64 - 6 - IDX_W;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOOKUP     = 3'd1;
  localparam logic [2:0] WB_REQ     = 3'd2;
  localparam logic [2:0] WB_WAIT    = 3'd3;
  localparam logic [2:0] FILL_REQ   = 3'd4;
  localparam logic [2:0] FILL_WAIT  = 3'd5;
  localparam logic [2:0] FL_WB_REQ  = 3'd6;
  localparam logic [2:0] FL_WB_WAIT = 3'd7;

  logic [2:0]       state;
  logic [63:3]      req_addr;
  logic [63:0]      req_wdata;
  logic             req_we;
  logic             req_fl;
  logic             abandon;
  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [511:0]     data_mem [SETS];
  logic [63:0]      daddr_q;
  logic [63:0]      rdata_q;
  logic             done_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word;
  logic             hit;
  logic             proceed;
  logic             fill_done;
  logic             wb_done;
  logic             store_hit;
  logic [63:0]      fill_line_addr;
  logic [63:0]      victim_addr;
  logic [63:0]      sel_word;

  assign idx            = req_addr[6 +: IDX_W];
  assign req_tag        = req_addr[63 -: TAG_W];
  assign word           = req_addr[5:3];
  assign hit            = valid[idx] && (tag_mem[idx] == req_tag);
  assign proceed        = bus.enable && !abandon;
  assign fill_line_addr = {req_addr[63:6], 6'b0};
  assign victim_addr    = {tag_mem[idx], idx, 6'b0};
  assign sel_word       = data_mem[idx][{word, 6'b0} +: 64];

  // A same-cycle dreqack+ddone counts as the ack immediately followed by the completion.
  assign fill_done = ((state == FILL_REQ) && bus.dreqack && bus.ddone) ||
                     ((state == FILL_WAIT) && bus.ddone);
  assign wb_done   = (((state == WB_REQ) || (state == FL_WB_REQ)) && bus.dreqack && bus.ddone) ||
                     (((state == WB_WAIT) || (state == FL_WB_WAIT)) && bus.ddone);
  assign store_hit = (state == LOOKUP) && proceed && !req_fl && req_we && hit;

  assign bus.drequest  = (state == WB_REQ) || (state == FILL_REQ) || (state == FL_WB_REQ);
  assign bus.dwrenable = (state == WB_REQ) || (state == WB_WAIT) ||
                         (state == FL_WB_REQ) || (state == FL_WB_WAIT);
  assign bus.daddr     = daddr_q;
  assign bus.dwdata    = data_mem[idx];
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      req_fl    <= 1'b0;
      abandon   <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
      daddr_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Once the core withdraws mid-miss, the transfer still finishes but no done is issued.
      if ((state != IDLE) && !bus.enable) abandon <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.enable && !done_q) begin
            req_addr  <= bus.addr[63:3];
            req_wdata <= bus.wdata;
            req_we    <= bus.wenable;
            req_fl    <= bus.clflush;
            abandon   <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!proceed) begin
            state <= IDLE;
          end else if (req_fl) begin
            if (hit && dirty[idx]) begin
              daddr_q <= fill_line_addr;
              state   <= FL_WB_REQ;
            end else begin
              if (hit) valid[idx] <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else if (hit) begin
            if (req_we) dirty[idx] <= 1'b1;
            else        rdata_q    <= sel_word;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (valid[idx] && dirty[idx]) begin
            daddr_q <= victim_addr;
            state   <= WB_REQ;
          end else begin
            daddr_q <= fill_line_addr;
            state   <= FILL_REQ;
          end
        end
        WB_REQ, WB_WAIT: begin
          if (wb_done) begin
            daddr_q <= fill_line_addr;
            state   <= FILL_REQ;
          end else if ((state == WB_REQ) && bus.dreqack) begin
            state <= WB_WAIT;
          end
        end
        FILL_REQ, FILL_WAIT: begin
          if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= LOOKUP;
          end else if ((state == FILL_REQ) && bus.dreqack) begin
            state <= FILL_WAIT;
          end
        end
        FL_WB_REQ, FL_WB_WAIT: begin
          if (wb_done) begin
            valid[idx] <= 1'b0;
            dirty[idx] <= 1'b0;
            done_q     <= proceed;
            state      <= IDLE;
          end else if ((state == FL_WB_REQ) && bus.dreqack) begin
            state <= FL_WB_WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= bus.drdata;
      tag_mem[idx]  <= req_tag;
    end else if (store_hit) begin
      data_mem[idx][{word, 6'b0} +: 64] <= req_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb: the bench plays both the core and a
// memory-backed arbiter, and every expected value below is hand-computed.
module tb_dcache_wb;
  logic clk;
  logic reset_n;
  dcache_wb_if bus ();

  dcache_wb #(.SETS(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [511:0] mem [logic [63:0]];

  logic         got_done;
  int           cycles;
  logic [63:0]  done_rdata;
  int           fill_count;
  int           wb_count;
  int           nreq;
  logic         first_wr;
  logic [63:0]  fill_addr;
  logic [63:0]  wb_addr;
  logic [511:0] wb_data;
  logic [63:0]  cur_daddr;
  logic         overlap;
  logic         seen;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: written-back lines persist; untouched lines follow a fixed pattern.
  function automatic logic [511:0] line_for(input logic [63:0] la);
    logic [511:0] l;
    if (mem.exists(la)) return mem[la];
    for (int k = 0; k < 8; k++)
      l[k*64 +: 64] = (la == 64'h1000) ? 64'h1122334455667788 + 64'(k)
                                       : {la[31:0], 32'hA0A0_0000 + 32'(k)};
    return l;
  endfunction

  // Runs one core request, serving the arbiter, until done or a 40-cycle budget runs out.
  task automatic apply_stimulus(input logic we, input logic fl, input logic [63:0] a,
                                input logic [63:0] wd, input logic same_cycle,
                                input logic drop_on_ack);
    logic pending;
    pending    = 1'b0;
    got_done   = 1'b0;
    cycles     = 0;
    fill_count = 0;
    wb_count   = 0;
    nreq       = 0;
    first_wr   = 1'b0;
    bus.enable  = 1'b1;
    bus.wenable = we;
    bus.clflush = fl;
    bus.addr    = a;
    bus.wdata   = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      bus.dreqack = 1'b0;
      bus.ddone   = 1'b0;
      if (bus.done && bus.drequest) overlap = 1'b1;
      if (bus.done) begin
        got_done   = 1'b1;
        cycles     = cyc;
        done_rdata = bus.rdata;
        break;
      end
      if (bus.drequest && !pending) begin
        nreq++;
        if (nreq == 1) first_wr = bus.dwrenable;
        cur_daddr = bus.daddr;
        if (bus.dwrenable) begin
          wb_count++;
          wb_addr = bus.daddr;
          wb_data = bus.dwdata;
          mem[bus.daddr] = bus.dwdata;
        end else begin
          fill_count++;
          fill_addr = bus.daddr;
        end
        bus.dreqack = 1'b1;
        if (same_cycle) begin
          bus.ddone  = 1'b1;
          bus.drdata = line_for(cur_daddr);
        end else begin
          pending = 1'b1;
        end
        if (drop_on_ack) bus.enable = 1'b0;
      end else if (pending) begin
        bus.ddone  = 1'b1;
        bus.drdata = line_for(cur_daddr);
        pending    = 1'b0;
      end
    end
    bus.enable  = 1'b0;
    bus.wenable = 1'b0;
    bus.clflush = 1'b0;
    @(posedge clk); #1;
    bus.dreqack = 1'b0;
    bus.ddone   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    overlap  = 1'b0;
    clk      = 1'b0;
    reset_n  = 1'b0;
    bus.enable  = 1'b0;
    bus.wenable = 1'b0;
    bus.clflush = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.dreqack = 1'b0;
    bus.ddone   = 1'b0;
    bus.drdata  = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("reset_done", bus.done, 0);
    check_output("reset_drequest", bus.drequest, 0);
    check_output("reset_dwrenable", bus.dwrenable, 0);
    check_output("reset_daddr", bus.daddr, 0);
    check_output("reset_rdata", bus.rdata, 0);

    // 1) cold load 0x1000
    apply_stimulus(0, 0, 64'h1000, 0, 0, 0);
    check_output("t1_done", got_done, 1);
    check_output("t1_fills", fill_count, 1);
    check_output("t1_wbs", wb_count, 0);
    check_output("t1_fill_addr", fill_addr, 64'h1000);
    check_output("t1_rdata", done_rdata, 64'h1122334455667788);

    // 2) load 0x1008 hits
    apply_stimulus(0, 0, 64'h1008, 0, 0, 0);
    check_output("t2_latency", cycles, 2);
    check_output("t2_nreq", nreq, 0);
    check_output("t2_rdata", done_rdata, 64'h1122334455667789);

    // 3) store then load 0x1010
    apply_stimulus(1, 0, 64'h1010, 64'hDEADBEEF, 0, 0);
    check_output("t3_store_latency", cycles, 2);
    check_output("t3_store_nreq", nreq, 0);
    check_output("t3_rdata_held", bus.rdata, 64'h1122334455667789);
    apply_stimulus(0, 0, 64'h1010, 0, 0, 0);
    check_output("t3_load_latency", cycles, 2);
    check_output("t3_load_nreq", nreq, 0);
    check_output("t3_load_rdata", done_rdata, 64'hDEADBEEF);

    // 4) conflict load 0x2000 evicts dirty 0x1000
    apply_stimulus(0, 0, 64'h2000, 0, 0, 0);
    check_output("t4_done", got_done, 1);
    check_output("t4_first_is_wb", first_wr, 1);
    check_output("t4_wbs", wb_count, 1);
    check_output("t4_wb_addr", wb_addr, 64'h1000);
    check_output("t4_wb_word2", wb_data[191:128], 64'hDEADBEEF);
    check_output("t4_wb_word0", wb_data[63:0], 64'h1122334455667788);
    check_output("t4_fills", fill_count, 1);
    check_output("t4_fill_addr", fill_addr, 64'h2000);
    check_output("t4_rdata", done_rdata, 64'h00002000_A0A00000);

    // 5) flush of dirty line, refill, flush of clean line, flush of absent line
    apply_stimulus(1, 0, 64'h2008, 64'h55, 0, 0);
    check_output("t5_store_nreq", nreq, 0);
    apply_stimulus(0, 1, 64'h2000, 0, 0, 0);
    check_output("t5_fl_done", got_done, 1);
    check_output("t5_fl_wbs", wb_count, 1);
    check_output("t5_fl_fills", fill_count, 0);
    check_output("t5_fl_wb_addr", wb_addr, 64'h2000);
    check_output("t5_fl_wb_word1", wb_data[127:64], 64'h55);
    apply_stimulus(0, 0, 64'h2008, 0, 1, 0);
    check_output("t5_reload_fills", fill_count, 1);
    check_output("t5_reload_wbs", wb_count, 0);
    check_output("t5_reload_rdata", done_rdata, 64'h55);
    apply_stimulus(0, 1, 64'h2000, 0, 0, 0);
    check_output("t5_clean_fl_latency", cycles, 2);
    check_output("t5_clean_fl_nreq", nreq, 0);
    apply_stimulus(0, 0, 64'h2000, 0, 0, 0);
    check_output("t5_after_clean_fl_fills", fill_count, 1);
    check_output("t5_after_clean_fl_rdata", done_rdata, 64'h00002000_A0A00000);
    apply_stimulus(0, 1, 64'h5040, 0, 0, 0);
    check_output("t5_absent_fl_latency", cycles, 2);
    check_output("t5_absent_fl_nreq", nreq, 0);

    // enable withdrawn during a miss: line installed, no done
    apply_stimulus(0, 0, 64'h3000, 0, 0, 1);
    check_output("drop_no_done", got_done, 0);
    check_output("drop_fills", fill_count, 1);
    apply_stimulus(0, 0, 64'h3000, 0, 0, 0);
    check_output("drop_then_hit_latency", cycles, 2);
    check_output("drop_then_hit_rdata", done_rdata, 64'h00003000_A0A00000);

    // 6) reset during FILL_WAIT
    bus.enable  = 1'b1;
    bus.wenable = 1'b0;
    bus.clflush = 1'b0;
    bus.addr    = 64'h1000;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.drequest) seen = 1'b1;
    end
    check_output("t6_fill_req_seen", seen, 1);
    bus.dreqack = 1'b1;
    @(posedge clk); #1;
    bus.dreqack = 1'b0;
    check_output("t6_wait_drequest", bus.drequest, 0);
    check_output("t6_wait_daddr", bus.daddr, 64'h1000);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_drequest", bus.drequest, 0);
    check_output("t6_rst_done", bus.done, 0);
    check_output("t6_rst_daddr", bus.daddr, 0);
    check_output("t6_rst_rdata", bus.rdata, 0);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("t6_post_rst_done", bus.done, 0);
    apply_stimulus(0, 0, 64'h1000, 0, 0, 0);
    check_output("t6_reload_fills", fill_count, 1);
    check_output("t6_reload_wbs", wb_count, 0);
    check_output("t6_reload_rdata", done_rdata, 64'h1122334455667788);
    apply_stimulus(0, 0, 64'h1010, 0, 0, 0);
    check_output("t6_persisted_store", done_rdata, 64'hDEADBEEF);

    check_output("done_never_with_drequest", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
